// File: rtl/spi_slave_responder.sv
// ============================================================================
// Module  : spi_slave_responder
// Brief   : SPI mode-0 slave with oversampled pins, single-entry TX holding
//           register and RX word register with overrun flag.
// Revision: 1.0  initial release
// ============================================================================
`default_nettype none

module spi_slave_responder #(
  parameter int               WIDTH       = 8,
  parameter int               SYNC_STAGES = 2,
  parameter logic [WIDTH-1:0] FILL        = WIDTH'(8'hFF)
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             sclk,
  input  logic             ss_n,
  input  logic             mosi,
  output logic             miso,
  output logic             miso_oe,
  input  logic [WIDTH-1:0] tx_data,
  input  logic             write,
  output logic             tx_full,
  output logic [WIDTH-1:0] rx_data,
  output logic             rx_valid,
  input  logic             read,
  output logic             overrun,
  output logic             busy
);

  typedef enum logic [0:0] {
    IDLE   = 1'b0,
    ACTIVE = 1'b1
  } state_t;

  localparam logic [WIDTH-1:0] c_last = WIDTH'(WIDTH - 1);

  state_t                 r_state;
  logic [SYNC_STAGES-1:0] r_sclk_sync;
  logic [SYNC_STAGES-1:0] r_ss_sync;
  logic [SYNC_STAGES-1:0] r_mosi_sync;
  logic                   r_sclk_prev;
  logic                   r_ss_prev;
  logic                   r_s_rise;
  logic                   r_s_fall;
  logic                   r_ss_fall;
  logic                   r_ss_rise;
  logic [WIDTH-1:0]       r_count;
  logic [WIDTH-1:0]       r_tx_shift;
  logic [WIDTH-2:0]       r_rx_shift;
  logic [WIDTH-1:0]       r_hold;
  logic                   r_tx_full;
  logic [WIDTH-1:0]       r_rx_data;
  logic                   r_rx_valid;
  logic                   r_overrun;

  logic                   w_sclk_s;
  logic                   w_ss_s;
  logic                   w_mosi_s;
  logic [WIDTH-1:0]       w_rx_word;
  logic                   w_reload;

  assign w_sclk_s  = r_sclk_sync[SYNC_STAGES-1];
  assign w_ss_s    = r_ss_sync[SYNC_STAGES-1];
  assign w_mosi_s  = r_mosi_sync[SYNC_STAGES-1];
  assign w_rx_word = {r_rx_shift, w_mosi_s};

  // Frame start: either a fresh select, or the SCLK fall that closes a frame
  // while still selected (back-to-back frames).
  assign w_reload = ((r_state == IDLE) && r_ss_fall) ||
                    ((r_state == ACTIVE) && !r_ss_rise && r_s_fall && (r_count == '0));

  always_ff @(posedge clk) begin
    if (clr) begin
      r_sclk_sync <= '0;
      r_ss_sync   <= '1;
      r_mosi_sync <= '0;
      r_sclk_prev <= 1'b0;
      r_ss_prev   <= 1'b1;
      r_s_rise    <= 1'b0;
      r_s_fall    <= 1'b0;
      r_ss_fall   <= 1'b0;
      r_ss_rise   <= 1'b0;
      r_state     <= IDLE;
      r_count     <= '0;
      r_tx_shift  <= '0;
      r_rx_shift  <= '0;
      r_hold      <= '0;
      r_tx_full   <= 1'b0;
      r_rx_data   <= '0;
      r_rx_valid  <= 1'b0;
      r_overrun   <= 1'b0;
    end else begin
      r_sclk_sync <= {r_sclk_sync[SYNC_STAGES-2:0], sclk};
      r_ss_sync   <= {r_ss_sync[SYNC_STAGES-2:0], ss_n};
      r_mosi_sync <= {r_mosi_sync[SYNC_STAGES-2:0], mosi};
      r_sclk_prev <= w_sclk_s;
      r_ss_prev   <= w_ss_s;
      r_s_rise    <= w_sclk_s & ~r_sclk_prev;
      r_s_fall    <= ~w_sclk_s & r_sclk_prev;
      r_ss_fall   <= ~w_ss_s & r_ss_prev;
      r_ss_rise   <= w_ss_s & ~r_ss_prev;

      if (read) r_rx_valid <= 1'b0;

      if (w_reload) begin
        r_tx_shift <= r_tx_full ? r_hold : FILL;
        r_tx_full  <= write;
        if (write) r_hold <= tx_data;
      end else if (write && !r_tx_full) begin
        r_hold    <= tx_data;
        r_tx_full <= 1'b1;
      end

      case (r_state)
        IDLE: begin
          if (r_ss_fall) begin
            r_state <= ACTIVE;
            r_count <= '0;
          end
        end
        ACTIVE: begin
          if (r_ss_rise) begin
            r_state <= IDLE;
            r_count <= '0;
          end else if (r_s_rise) begin
            r_rx_shift <= w_rx_word[WIDTH-2:0];
            if (r_count == c_last) begin
              r_rx_data  <= w_rx_word;
              r_rx_valid <= 1'b1;
              r_count    <= '0;
              if (r_rx_valid && !read) r_overrun <= 1'b1;
            end else begin
              r_count <= r_count + WIDTH'(1);
            end
          end else if (r_s_fall && (r_count != '0)) begin
            r_tx_shift <= r_tx_shift << 1;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign miso     = (r_state == ACTIVE) ? r_tx_shift[WIDTH-1] : 1'b0;
  assign miso_oe  = (r_state == ACTIVE);
  assign busy     = (r_state == ACTIVE);
  assign tx_full  = r_tx_full;
  assign rx_data  = r_rx_data;
  assign rx_valid = r_rx_valid;
  assign overrun  = r_overrun;

endmodule

`default_nettype wire

// File: tb/tb_spi_slave_responder.sv
// ============================================================================
// Module  : tb_spi_slave_responder
// Brief   : Drives the slave as an SPI mode-0 master and compares it against a
//           frame-level reference model.
// Revision: 1.0  initial release
// ============================================================================
`default_nettype none

module tb_spi_slave_responder;

  localparam int         WIDTH       = 8;
  localparam int         SYNC_STAGES = 2;
  localparam logic [7:0] FILL        = 8'hFF;

  logic       clk = 1'b0;
  logic       clr = 1'b1;
  logic       sclk = 1'b0;
  logic       ss_n = 1'b1;
  logic       mosi = 1'b0;
  logic       miso;
  logic       miso_oe;
  logic [7:0] tx_data = 8'h00;
  logic       write = 1'b0;
  logic       tx_full;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       read = 1'b0;
  logic       overrun;
  logic       busy;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model: holding register, word currently on the wire, RX state.
  logic       m_full, m_valid, m_ovr;
  logic [7:0] m_hold, m_cur, m_rx;

  spi_slave_responder #(
    .WIDTH(WIDTH), .SYNC_STAGES(SYNC_STAGES), .FILL(FILL)
  ) dut (
    .clk(clk), .clr(clr), .sclk(sclk), .ss_n(ss_n), .mosi(mosi),
    .miso(miso), .miso_oe(miso_oe), .tx_data(tx_data), .write(write),
    .tx_full(tx_full), .rx_data(rx_data), .rx_valid(rx_valid), .read(read),
    .overrun(overrun), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    m_full = 0; m_valid = 0; m_ovr = 0; m_hold = 0; m_cur = 0; m_rx = 0;
  endtask

  function automatic logic [7:0] next_word();
    logic [7:0] w;
    w = m_full ? m_hold : FILL;
    m_full = 0;
    return w;
  endfunction

  task automatic host_write(input logic [7:0] d);
    @(negedge clk); write = 1; tx_data = d;
    @(negedge clk); write = 0;
    if (!m_full) begin m_full = 1; m_hold = d; end
  endtask

  task automatic host_read();
    @(negedge clk); read = 1;
    @(negedge clk); read = 0;
    m_valid = 0;
  endtask

  task automatic select();
    @(negedge clk); ss_n = 0;
    m_cur = next_word();
    repeat (8) @(negedge clk);
  endtask

  // Write strobe timed to land on the same clock as the select reload.
  task automatic select_with_write(input logic [7:0] d);
    @(negedge clk); ss_n = 0;
    repeat (SYNC_STAGES + 1) @(posedge clk);
    @(negedge clk); write = 1; tx_data = d;
    @(negedge clk); write = 0;
    m_cur = next_word();
    m_full = 1; m_hold = d;
    repeat (6) @(negedge clk);
  endtask

  task automatic deselect();
    @(negedge clk); ss_n = 1;
    repeat (8) @(negedge clk);
  endtask

  // Master shifts nbits of mo; returns what it sampled on MISO.
  task automatic shift_frame(input logic [7:0] mo, input int nbits, output logic [7:0] mi);
    logic [7:0] exp_mi;
    mi = 0;
    for (int i = 0; i < nbits; i++) begin
      mosi = mo[7-i];
      repeat (4) @(negedge clk);
      mi = {mi[6:0], miso};
      sclk = 1;
      repeat (4) @(negedge clk);
      sclk = 0;
    end
    repeat (8) @(negedge clk);
    exp_mi = m_cur >> (8 - nbits);
    check("miso_word", {24'h0, mi}, {24'h0, exp_mi});
    if (nbits == 8) begin
      if (m_valid) m_ovr = 1;
      m_rx = mo; m_valid = 1;
      m_cur = next_word();
    end
  endtask

  task automatic check_state(input string tag);
    check({tag, "_rx_data"},  {24'h0, rx_data}, {24'h0, m_rx});
    check({tag, "_rx_valid"}, {31'h0, rx_valid}, {31'h0, m_valid});
    check({tag, "_overrun"},  {31'h0, overrun}, {31'h0, m_ovr});
    check({tag, "_tx_full"},  {31'h0, tx_full}, {31'h0, m_full});
  endtask

  initial begin
    logic [7:0] mi;
    model_reset();
    repeat (4) @(negedge clk);
    clr = 0;
    @(negedge clk);
    check("rst_miso", {31'h0, miso}, 0);
    check("rst_miso_oe", {31'h0, miso_oe}, 0);
    check("rst_busy", {31'h0, busy}, 0);
    check_state("rst");

    // 1: loaded word goes out, master word comes in
    host_write(8'hA5);
    check("t1_full", {31'h0, tx_full}, 1);
    select();
    check("t1_busy", {31'h0, busy}, 1);
    check("t1_oe", {31'h0, miso_oe}, 1);
    shift_frame(8'h3C, 8, mi);
    deselect();
    check("t1_idle", {31'h0, busy}, 0);
    check_state("t1");

    // 2: empty holding register sends FILL
    host_read();
    select(); shift_frame(8'h5A, 8, mi); deselect();
    check_state("t2");

    // 3: back-to-back frames without READ set OVERRUN
    host_read();
    select(); shift_frame(8'h11, 8, mi); shift_frame(8'h22, 8, mi); deselect();
    check_state("t3");

    // 4: aborted frame, then a clean frame
    host_read();
    select(); shift_frame(8'hF0, 4, mi); deselect();
    check("t4_busy", {31'h0, busy}, 0);
    check_state("t4a");
    select(); shift_frame(8'h0F, 8, mi); deselect();
    check_state("t4b");

    // 5: WRITE coincides with the select reload
    host_write(8'h96);
    select_with_write(8'h69);
    check("t5_full", {31'h0, tx_full}, 1);
    shift_frame(8'hC3, 8, mi);
    deselect();
    check_state("t5");

    // 6: reset in the middle of a frame
    host_write(8'h3E);
    select();
    shift_frame(8'h81, 5, mi);
    @(negedge clk); clr = 1; ss_n = 1;
    @(negedge clk); clr = 0;
    model_reset();
    check("t6_miso", {31'h0, miso}, 0);
    check("t6_oe", {31'h0, miso_oe}, 0);
    check("t6_busy", {31'h0, busy}, 0);
    check_state("t6a");
    repeat (8) @(negedge clk);
    host_write(8'h7E);
    select(); shift_frame(8'hB4, 8, mi); deselect();
    check_state("t6b");

    // Randomised traffic
    for (int it = 0; it < 16; it++) begin
      int nw, nfr;
      nw = $urandom_range(0, 2);
      for (int w = 0; w < nw; w++) host_write(8'($urandom));
      if ($urandom_range(0, 2) == 0) host_read();
      nfr = $urandom_range(1, 2);
      select();
      for (int f = 0; f < nfr; f++) begin
        if (f == nfr - 1 && $urandom_range(0, 3) == 0)
          shift_frame(8'($urandom), $urandom_range(1, 7), mi);
        else
          shift_frame(8'($urandom), 8, mi);
      end
      deselect();
      check_state("rnd");
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout got=%0d exp=%0d", 0, 1);
    $fatal(1, "timeout");
  end

endmodule

`default_nettype wire
